id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the uP16 5-stage pipeline, directly downstream of instruction fetch.
//  Decodes the 18-bit instruction word and reads a 16x16 register file, which is written by write-back.
//  Resolves BEQ/BNE/J/JAL in ID and returns sel_PC/alt_PC to fetch combinationally, so there is no delay slot and no flush.
//  Registers the decoded operands and controls into the ID/EX pipeline register.
// PARAMETERS
//  ISIZE  18  instruction width
//  DSIZE  16  data/PC width
//  NREG   16  register count (address width 4); R0 reads 0 and is never written
// PORTS
//  Clk        in   1      sole clock, rising edge
//  Rst        in   1      synchronous, active-high reset
//  inst       in   ISIZE  instruction from fetch (synchronous memory output)
//  PCplus1    in   DSIZE  PC+1 of the instruction in inst
//  wb_en      in   1      write-back enable
//  wb_addr    in   4      write-back register
//  wb_data    in   DSIZE  write-back data
//  sel_PC     out  1      redirect fetch (combinational)
//  alt_PC     out  DSIZE  redirect target (combinational)
//  ex_alu_op  out  3      0 ADD,1 SUB,2 AND,3 OR,4 SLT
//  ex_a       out  DSIZE  operand A (R[rs], or PCplus1 for JAL)
//  ex_b       out  DSIZE  operand B (R[rt]; for SW: store data R[rd])
//  ex_imm     out  DSIZE  sign-extended imm6
//  ex_use_imm out  1      ALU B = ex_imm
//  ex_rd      out  4      destination register
//  ex_reg_we  out  1      write-back enable for EX
//  ex_mem_rd  out  1      load
//  ex_mem_wr  out  1      store
//  ex_illegal out  1      reserved opcode seen (sticky until Rst)
// BEHAVIOUR
//  Formats:
//   - R: op[17:14] rd[13:10] rs[9:6] rt[5:2]
//   - I (ADDI/LW/SW): op rd rs imm6[5:0]
//   - B (BEQ/BNE): op rs[13:10] rt[9:6] off6[5:0]
//   - J/JAL: op tgt14[13:0]
//  Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, A BNE, B J, C JAL, D-F reserved.
//  Reserved opcodes decode as NOP and set ex_illegal on the next edge.
//  Branch: taken when (R[rs]==R[rt]) for BEQ and (!=) for BNE.
//   - Taken: sel_PC=1, alt_PC = PCplus1 + sext(off6), mod 2^16 (wrap FFFF+1 -> 0000).
//   - Not taken: sel_PC=0.
//  J/JAL: sel_PC=1, alt_PC = {PCplus1[15:14], tgt14}.
//  JAL: ex_rd=15, ex_reg_we=1, ex_a=PCplus1, ex_b=0, ex_alu_op=ADD, ex_use_imm=0.
//  Branches, J and SW: ex_reg_we=0. NOP: all ex_* controls 0.
//  Latency: one cycle from inst to ex_*; sel_PC/alt_PC in the same cycle.
//  Register file:
//   - Write on posedge when wb_en && wb_addr!=0.
//   - Reads are combinational.
//   - Any read of R0 returns 0, including a bypass with wb_addr=0.
//  Hazards: no stall or forwarding from EX/MEM. Software places >=2 independent instructions between a producer and a consumer in ID (3 without the bypass).
//  Reset:
//   - While Rst: all ex_* registered to 0, sel_PC forced 0, alt_PC=0, ex_illegal cleared.
//   - Register file cleared to 0 (loop over NREG, one cycle).
//   - A wb write in the same cycle as Rst is dropped.
//  Simultaneous: a branch reading the register being written sees the bypassed value (config below).
// CONFIGURATION
//  ID_WB_BYPASS_EN defined:
//   - Read of R[x] with wb_en && wb_addr==x && x!=0 returns wb_data in the same cycle.
//   - Applies to operands and to the branch compare.
//  Undefined: reads return the stored (old) value; the write is visible from the next cycle.
// STRUCTURE
//  Shared package uP16_pkg:
//   - Opcode constants OP_NOP..OP_JAL.
//   - ALU_ADD..ALU_SLT.
//   - Field bit positions.
//   - LINK_REG=15.
//  Sub-module uP16_regfile (2 read ports, 1 write port, bypass, R0=0), instantiated once.
//  Decode, branch compare and the ID/EX register live in id_stage.
// TESTING
//  1. Rst 2 cycles -> all ex_*=0, sel_PC=0; R1..R15 read 0 after reset.
//  2. wb R3=0x1234, wait 1, ADD R5,R3,R0 -> next edge ex_a=0x1234, ex_b=0, ex_rd=5, ex_reg_we=1, ex_alu_op=0.
//  3. R1=R2=7, PCplus1=0x0010, BEQ R1,R2,off=-3 -> sel_PC=1, alt_PC=0x000D; repeat as BNE -> sel_PC=0.
//  4. PCplus1=0xFFFF, BEQ R0,R0,off=+1 -> alt_PC=0x0000 (wrap).
//  5. JAL tgt=0x0100, PCplus1=0x4005 -> alt_PC=0x4100, ex_rd=15, ex_a=0x4005, ex_reg_we=1.
//  6. wb R4=0xBEEF in same cycle as ADD R6,R4,R4:
//     - With ID_WB_BYPASS_EN: ex_a=ex_b=0xBEEF.
//     - Without it: old R4.
//     - wb to R0 -> R0 still 0.
//     - opcode 0xE -> NOP controls, ex_illegal=1 until Rst.

Source files
------------

// File: rtl/uP16_pkg.sv
// Shared uP16 definitions: widths, opcodes, ALU codes, instruction field positions
// and the ID/EX pipeline payload.
package uP16_pkg;

   localparam int unsigned ISIZE   = 18;
   localparam int unsigned DSIZE   = 16;
   localparam int unsigned NREG    = 16;
   localparam int unsigned RADDR_W = 4;
   localparam int unsigned ALU_W   = 3;
   localparam int unsigned OP_W    = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
   localparam logic [OP_W-1:0] OP_AND  = 4'h3;
   localparam logic [OP_W-1:0] OP_OR   = 4'h4;
   localparam logic [OP_W-1:0] OP_SLT  = 4'h5;
   localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
   localparam logic [OP_W-1:0] OP_LW   = 4'h7;
   localparam logic [OP_W-1:0] OP_SW   = 4'h8;
   localparam logic [OP_W-1:0] OP_BEQ  = 4'h9;
   localparam logic [OP_W-1:0] OP_BNE  = 4'hA;
   localparam logic [OP_W-1:0] OP_J    = 4'hB;
   localparam logic [OP_W-1:0] OP_JAL  = 4'hC;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
   localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'd4;

   localparam int unsigned OP_HI  = 17;
   localparam int unsigned OP_LO  = 14;
   localparam int unsigned RD_HI  = 13;
   localparam int unsigned RD_LO  = 10;
   localparam int unsigned RS_HI  = 9;
   localparam int unsigned RS_LO  = 6;
   localparam int unsigned RT_HI  = 5;
   localparam int unsigned RT_LO  = 2;
   localparam int unsigned IMM_HI = 5;
   localparam int unsigned IMM_LO = 0;
   localparam int unsigned TGT_HI = 13;
   localparam int unsigned TGT_LO = 0;

   localparam logic [RADDR_W-1:0] LINK_REG = 4'd15;

   typedef struct packed {
      logic [ALU_W-1:0]   alu_op;
      logic [DSIZE-1:0]   a;
      logic [DSIZE-1:0]   b;
      logic [DSIZE-1:0]   imm;
      logic               use_imm;
      logic [RADDR_W-1:0] rd;
      logic               reg_we;
      logic               mem_rd;
      logic               mem_wr;
      logic               illegal;
   } id_ex_t;

   function automatic logic [DSIZE-1:0] sext6(input logic [5:0] v);
      return {{10{v[5]}}, v};
   endfunction

endpackage

// File: rtl/uP16_regfile.sv
// 16x16 register file: two combinational read ports, one write port, R0 hard-wired to 0.
// Same-cycle write-to-read bypass is built when ID_WB_BYPASS_EN is defined.
module uP16_regfile
   import uP16_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               we_i,
   input  logic [RADDR_W-1:0] waddr_i,
   input  logic [DSIZE-1:0]   wdata_i,
   input  logic [RADDR_W-1:0] raddr_a_i,
   input  logic [RADDR_W-1:0] raddr_b_i,
   output logic [DSIZE-1:0]   rdata_a_c_o,
   output logic [DSIZE-1:0]   rdata_b_c_o
);

   logic [DSIZE-1:0] regs_q [NREG];

   // Reset clears every entry in one cycle and drops a coincident write
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_a_c_o = regs_q[raddr_a_i];
`ifdef ID_WB_BYPASS_EN
      if (we_i && (waddr_i == raddr_a_i)) rdata_a_c_o = wdata_i;
`endif
      if (raddr_a_i == '0) rdata_a_c_o = '0;
   end

   always_comb begin
      rdata_b_c_o = regs_q[raddr_b_i];
`ifdef ID_WB_BYPASS_EN
      if (we_i && (waddr_i == raddr_b_i)) rdata_b_c_o = wdata_i;
`endif
      if (raddr_b_i == '0) rdata_b_c_o = '0;
   end

endmodule

// File: rtl/id_stage.sv
// uP16 instruction-decode stage: decode, register read, branch/jump resolve, ID/EX register.
// Optional same-cycle write-back bypass selected by ID_WB_BYPASS_EN.
module id_stage
   import uP16_pkg::*;
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic [ISIZE-1:0]   inst,
   input  logic [DSIZE-1:0]   PCplus1,
   input  logic               wb_en,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [DSIZE-1:0]   wb_data,
   output logic               sel_PC,
   output logic [DSIZE-1:0]   alt_PC,
   output logic [ALU_W-1:0]   ex_alu_op,
   output logic [DSIZE-1:0]   ex_a,
   output logic [DSIZE-1:0]   ex_b,
   output logic [DSIZE-1:0]   ex_imm,
   output logic               ex_use_imm,
   output logic [RADDR_W-1:0] ex_rd,
   output logic               ex_reg_we,
   output logic               ex_mem_rd,
   output logic               ex_mem_wr,
   output logic               ex_illegal
);

   logic [OP_W-1:0]    op;
   logic [RADDR_W-1:0] ra_addr;
   logic [RADDR_W-1:0] rb_addr;
   logic [DSIZE-1:0]   ra_data;
   logic [DSIZE-1:0]   rb_data;
   id_ex_t             id_ex_d;
   id_ex_t             id_ex_q;

   assign op = inst[OP_HI:OP_LO];

   // Branches carry rs/rt in the upper fields; SW reads its store data from rd
   always_comb begin
      ra_addr = inst[RS_HI:RS_LO];
      rb_addr = inst[RT_HI:RT_LO];
      case (op)
         OP_BEQ, OP_BNE: begin
            ra_addr = inst[RD_HI:RD_LO];
            rb_addr = inst[RS_HI:RS_LO];
         end
         OP_SW:   rb_addr = inst[RD_HI:RD_LO];
         default: ;
      endcase
   end

   uP16_regfile u_regfile (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .we_i        (wb_en),
      .waddr_i     (wb_addr),
      .wdata_i     (wb_data),
      .raddr_a_i   (ra_addr),
      .raddr_b_i   (rb_addr),
      .rdata_a_c_o (ra_data),
      .rdata_b_c_o (rb_data)
   );

   // Redirect is resolved here so fetch never needs a delay slot or flush
   always_comb begin
      sel_PC = 1'b0;
      alt_PC = '0;
      if (!Rst) begin
         case (op)
            OP_BEQ, OP_BNE: begin
               if ((ra_data == rb_data) == (op == OP_BEQ)) begin
                  sel_PC = 1'b1;
                  alt_PC = DSIZE'(PCplus1 + sext6(inst[IMM_HI:IMM_LO]));
               end
            end
            OP_J, OP_JAL: begin
               sel_PC = 1'b1;
               alt_PC = {PCplus1[DSIZE-1:TGT_HI+1], inst[TGT_HI:TGT_LO]};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      id_ex_d         = '0;
      id_ex_d.illegal = id_ex_q.illegal;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
            id_ex_d.alu_op = ALU_W'(op - OP_ADD);
            id_ex_d.a      = ra_data;
            id_ex_d.b      = rb_data;
            id_ex_d.rd     = inst[RD_HI:RD_LO];
            id_ex_d.reg_we = 1'b1;
         end
         OP_ADDI, OP_LW: begin
            id_ex_d.alu_op  = ALU_ADD;
            id_ex_d.a       = ra_data;
            id_ex_d.imm     = sext6(inst[IMM_HI:IMM_LO]);
            id_ex_d.use_imm = 1'b1;
            id_ex_d.rd      = inst[RD_HI:RD_LO];
            id_ex_d.reg_we  = 1'b1;
            id_ex_d.mem_rd  = (op == OP_LW);
         end
         OP_SW: begin
            id_ex_d.alu_op  = ALU_ADD;
            id_ex_d.a       = ra_data;
            id_ex_d.b       = rb_data;
            id_ex_d.imm     = sext6(inst[IMM_HI:IMM_LO]);
            id_ex_d.use_imm = 1'b1;
            id_ex_d.mem_wr  = 1'b1;
         end
         OP_JAL: begin
            id_ex_d.alu_op = ALU_ADD;
            id_ex_d.a      = PCplus1;
            id_ex_d.rd     = LINK_REG;
            id_ex_d.reg_we = 1'b1;
         end
         OP_NOP, OP_BEQ, OP_BNE, OP_J: ;
         default: id_ex_d.illegal = 1'b1;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) id_ex_q <= '0;
      else     id_ex_q <= id_ex_d;
   end

   assign ex_alu_op  = id_ex_q.alu_op;
   assign ex_a       = id_ex_q.a;
   assign ex_b       = id_ex_q.b;
   assign ex_imm     = id_ex_q.imm;
   assign ex_use_imm = id_ex_q.use_imm;
   assign ex_rd      = id_ex_q.rd;
   assign ex_reg_we  = id_ex_q.reg_we;
   assign ex_mem_rd  = id_ex_q.mem_rd;
   assign ex_mem_wr  = id_ex_q.mem_wr;
   assign ex_illegal = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage; expectations for the write-back bypass follow ID_WB_BYPASS_EN.
module tb_id_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [17:0] inst;
   logic [15:0] PCplus1;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        sel_PC;
   logic [15:0] alt_PC;
   logic [2:0]  ex_alu_op;
   logic [15:0] ex_a, ex_b, ex_imm;
   logic        ex_use_imm;
   logic [3:0]  ex_rd;
   logic        ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef ID_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   id_stage dut (
      .Clk(Clk), .Rst(Rst), .inst(inst), .PCplus1(PCplus1),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .sel_PC(sel_PC), .alt_PC(alt_PC), .ex_alu_op(ex_alu_op),
      .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_use_imm(ex_use_imm),
      .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal)
   );

   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] enc_r(input logic [3:0] op, rd, rs, rt);
      return {op, rd, rs, rt, 2'b00};
   endfunction
   function automatic logic [17:0] enc_i(input logic [3:0] op, rd, rs, input logic [5:0] imm);
      return {op, rd, rs, imm};
   endfunction
   function automatic logic [17:0] enc_b(input logic [3:0] op, rs, rt, input logic [5:0] off);
      return {op, rs, rt, off};
   endfunction
   function automatic logic [17:0] enc_j(input logic [3:0] op, input logic [13:0] tgt);
      return {op, tgt};
   endfunction

   initial begin
      Rst = 1'b0; inst = '0; PCplus1 = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;

      // Fill registers with nonzero data so reset clearing is observable
      for (int i = 1; i < 16; i++) begin
         wb_en = 1'b1; wb_addr = 4'(i); wb_data = 16'hA000 + 16'(i);
         tick;
      end

      // Reset with a jump and a write present: redirect suppressed, write dropped
      Rst = 1'b1; inst = enc_j(4'hB, 14'h0123); PCplus1 = 16'h1234;
      wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'hAAAA;
      #1;
      chk("rst_sel_pc", 16'(sel_PC), 16'h0);
      chk("rst_alt_pc", alt_PC, 16'h0);
      tick; tick;
      chk("rst_sel_pc2", 16'(sel_PC), 16'h0);
      chk("rst_ex_a", ex_a, 16'h0);
      chk("rst_ex_b", ex_b, 16'h0);
      chk("rst_ex_imm", ex_imm, 16'h0);
      chk("rst_ex_rd", 16'(ex_rd), 16'h0);
      chk("rst_ex_ctl", 16'({ex_alu_op, ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal}), 16'h0);
      Rst = 1'b0; wb_en = 1'b0; inst = '0; PCplus1 = '0;

      for (int k = 1; k < 16; k++) begin
         inst = enc_r(4'h1, 4'd1, 4'(k), 4'(k));
         tick;
         chk($sformatf("reg_clear_a_r%0d", k), ex_a, 16'h0);
         chk($sformatf("reg_clear_b_r%0d", k), ex_b, 16'h0);
      end

      // ADD R5,R3,R0 after writing R3
      inst = '0; wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
      tick;
      wb_en = 1'b0; inst = enc_r(4'h1, 4'd5, 4'd3, 4'd0);
      tick;
      chk("add_ex_a", ex_a, 16'h1234);
      chk("add_ex_b", ex_b, 16'h0);
      chk("add_ex_rd", 16'(ex_rd), 16'h5);
      chk("add_ex_we", 16'(ex_reg_we), 16'h1);
      chk("add_ex_alu", 16'(ex_alu_op), 16'h0);
      chk("add_ex_use_imm", 16'(ex_use_imm), 16'h0);

      // BEQ/BNE with R1=R2=7
      inst = '0; wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h0007;
      tick;
      wb_addr = 4'd2;
      tick;
      wb_en = 1'b0; PCplus1 = 16'h0010; inst = enc_b(4'h9, 4'd1, 4'd2, 6'h3D);
      #1;
      chk("beq_sel", 16'(sel_PC), 16'h1);
      chk("beq_alt", alt_PC, 16'h000D);
      tick;
      chk("beq_no_we", 16'(ex_reg_we), 16'h0);
      inst = enc_b(4'hA, 4'd1, 4'd2, 6'h3D);
      #1;
      chk("bne_sel", 16'(sel_PC), 16'h0);

      // Branch target wraps at 16 bits
      PCplus1 = 16'hFFFF; inst = enc_b(4'h9, 4'd0, 4'd0, 6'h01);
      #1;
      chk("wrap_sel", 16'(sel_PC), 16'h1);
      chk("wrap_alt", alt_PC, 16'h0000);
      tick;

      // JAL keeps PC upper bits and links into R15
      PCplus1 = 16'h4005; inst = enc_j(4'hC, 14'h0100);
      #1;
      chk("jal_sel", 16'(sel_PC), 16'h1);
      chk("jal_alt", alt_PC, 16'h4100);
      tick;
      chk("jal_rd", 16'(ex_rd), 16'hF);
      chk("jal_a", ex_a, 16'h4005);
      chk("jal_b", ex_b, 16'h0);
      chk("jal_we", 16'(ex_reg_we), 16'h1);
      chk("jal_alu", 16'(ex_alu_op), 16'h0);
      chk("jal_use_imm", 16'(ex_use_imm), 16'h0);

      // Remaining ALU and memory forms
      PCplus1 = 16'h0000;
      inst = enc_r(4'h2, 4'd8, 4'd3, 4'd1);
      tick;
      chk("sub_alu", 16'(ex_alu_op), 16'h1);
      chk("sub_a", ex_a, 16'h1234);
      chk("sub_b", ex_b, 16'h0007);
      inst = enc_r(4'h5, 4'd8, 4'd3, 4'd1);
      tick;
      chk("slt_alu", 16'(ex_alu_op), 16'h4);
      inst = enc_i(4'h6, 4'd9, 4'd3, 6'h3E);
      tick;
      chk("addi_imm", ex_imm, 16'hFFFE);
      chk("addi_ctl", 16'({ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr}), 16'b1100);
      chk("addi_rd", 16'(ex_rd), 16'h9);
      inst = enc_i(4'h7, 4'd9, 4'd3, 6'h04);
      tick;
      chk("lw_ctl", 16'({ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr}), 16'b1110);
      chk("lw_imm", ex_imm, 16'h0004);
      inst = enc_i(4'h8, 4'd3, 4'd1, 6'h05);
      tick;
      chk("sw_ctl", 16'({ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr}), 16'b1001);
      chk("sw_a", ex_a, 16'h0007);
      chk("sw_b", ex_b, 16'h1234);
      chk("sw_imm", ex_imm, 16'h0005);

      // Write-back in the same cycle as a read of that register
      inst = '0; wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h1111;
      tick;
      wb_data = 16'hBEEF; inst = enc_r(4'h1, 4'd6, 4'd4, 4'd4);
      tick;
      chk("byp_a", ex_a, BYP ? 16'hBEEF : 16'h1111);
      chk("byp_b", ex_b, BYP ? 16'hBEEF : 16'h1111);
      wb_en = 1'b0;
      tick;
      chk("after_wb_a", ex_a, 16'hBEEF);

      // Branch compare sees the bypass too: R7 is 0, being written with 5
      wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h0005;
      PCplus1 = 16'h0020; inst = enc_b(4'h9, 4'd7, 4'd0, 6'h02);
      #1;
      chk("byp_beq_sel", 16'(sel_PC), BYP ? 16'h0 : 16'h1);
      tick;
      wb_en = 1'b0;

      // Writes to R0 are ignored, bypassed or not
      wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'h5555;
      inst = enc_r(4'h1, 4'd1, 4'd0, 4'd0);
      tick;
      chk("r0_byp_a", ex_a, 16'h0);
      chk("r0_byp_b", ex_b, 16'h0);
      wb_en = 1'b0;
      tick;
      chk("r0_stored_a", ex_a, 16'h0);

      // Reserved opcode: NOP controls, sticky illegal until reset
      inst = {4'hE, 14'h3FFF};
      #1;
      chk("rsv_sel", 16'(sel_PC), 16'h0);
      tick;
      chk("rsv_illegal", 16'(ex_illegal), 16'h1);
      chk("rsv_ctl", 16'({ex_alu_op, ex_use_imm, ex_reg_we, ex_mem_rd, ex_mem_wr}), 16'h0);
      chk("rsv_rd", 16'(ex_rd), 16'h0);
      inst = '0;
      tick;
      chk("illegal_sticky", 16'(ex_illegal), 16'h1);
      Rst = 1'b1;
      tick;
      chk("illegal_cleared", 16'(ex_illegal), 16'h0);
      Rst = 1'b0;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
